// File: rtl/skel_delete_queue_if.sv
// Deletion-queue handshake bundle: scan-side request port plus write-mux and pass-status outputs.
interface skel_delete_queue_if #(
  parameter int unsigned bitSize = 6,
  parameter int unsigned CNT_W   = 7
);
  logic               pass_start;
  logic               pass_end;
  logic               del_valid;
  logic [bitSize-1:0] del_addr;
  logic               del_ready;
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               pass_done;
  logic               changed;
  logic [CNT_W-1:0]   del_count;
  logic               busy;

  modport master (
    output pass_start, pass_end, del_valid, del_addr,
    input  del_ready, wr_en, wr_data, pass_done, changed, del_count, busy
  );

  modport slave (
    input  pass_start, pass_end, del_valid, del_addr,
    output del_ready, wr_en, wr_data, pass_done, changed, del_count, busy
  );
endinterface

// File: rtl/skel_delete_queue.sv
// Buffers one thinning sub-iteration's pixel deletions and replays them as 2-cycle mux writes.
// Optional SKEL_DELETE_QUEUE_DEDUP_EN drops a push repeating the previous accepted address.
module skel_delete_queue #(
  parameter int unsigned N       = 8,
  parameter int unsigned bitSize = 6,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 7
) (
  input logic                clk,
  input logic                rst_n,
  skel_delete_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || ((1 << bitSize) < N * N)) begin : g_bad_cfg
    $error("skel_delete_queue: DEPTH must be a power of two >= 2 and bitSize must cover N*N");
  end

  localparam logic [PtrW:0]    PtrOne = 1;
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [bitSize-1:0] mem_q [DEPTH];
  logic [PtrW:0]      wptr_q, rptr_q;
  logic               wr_en_q, phase_q;
  logic [7:0]         wr_data_q;
  logic [CNT_W-1:0]   del_count_q, del_count_d;
  logic               changed_q, changed_d;

  logic full, empty, del_ready, push_acc, push, pop, hold_end, start, dup;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign start    = (state_q == StIdle) && bus.pass_start;
  // No bypass: a full FIFO refuses even when it pops on the same edge.
  assign del_ready = (state_q == StCollect) && !full;
  assign push_acc = bus.del_valid && del_ready;
  assign push     = push_acc && !dup;
  assign hold_end = wr_en_q && phase_q;
  assign pop      = !empty && (!wr_en_q || hold_end);

`ifdef SKEL_DELETE_QUEUE_DEDUP_EN
  logic [bitSize-1:0] last_q;
  logic               last_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (start) begin
      last_vld_q <= 1'b0;
    end else if (push_acc) begin
      last_q     <= bus.del_addr;
      last_vld_q <= 1'b1;
    end
  end

  assign dup = last_vld_q && (last_q == bus.del_addr);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.pass_start) state_d = StCollect;
      StCollect: if (bus.pass_end)   state_d = StDrain;
      StDrain:   if (empty && !wr_en_q) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    del_count_d = del_count_q;
    changed_d   = changed_q;
    if (start) begin
      del_count_d = '0;
      changed_d   = 1'b0;
    end else begin
      if (pop && (del_count_q != CntMax)) del_count_d = del_count_q + CntOne;
      if (state_q == StDone) changed_d = (del_count_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      del_count_q <= '0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      del_count_q <= del_count_d;
      changed_q   <= changed_d;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= bus.del_addr;
  end

  // Each write is held for two cycles so the alternately-sampling mux catches it in either phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      phase_q   <= 1'b0;
      wr_data_q <= '0;
    end else if (pop) begin
      wr_en_q   <= 1'b1;
      phase_q   <= 1'b0;
      wr_data_q <= 8'(mem_q[rptr_q[PtrW-1:0]]);
    end else if (hold_end) begin
      wr_en_q   <= 1'b0;
      phase_q   <= 1'b0;
      wr_data_q <= '0;
    end else if (wr_en_q) begin
      phase_q   <= 1'b1;
    end
  end

  assign bus.del_ready = del_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.pass_done = (state_q == StDone);
  assign bus.changed   = changed_q;
  assign bus.del_count = del_count_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_skel_delete_queue.sv
// Directed bench for skel_delete_queue: reset, basic/empty passes, backpressure, reset mid-drain,
// and repeated-address handling (expectations follow SKEL_DELETE_QUEUE_DEDUP_EN).
module tb_skel_delete_queue;

  logic clk = 1'b0;
  logic rst_n;

  skel_delete_queue_if #(.bitSize(6), .CNT_W(7)) bus ();

  skel_delete_queue #(
    .N      (8),
    .bitSize(6),
    .DEPTH  (8),
    .CNT_W  (7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int          cyc = 0;
  logic [7:0]  wq[$];
  int          run, first_en, last_en, done_cyc, done_cnt;
  bit          en_seen;
  logic [7:0]  cur;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reassembles writes from the wr_en/wr_data stream and checks each is held exactly two cycles.
  initial begin
    run = 0; done_cnt = 0; en_seen = 0; first_en = 0; last_en = 0; done_cyc = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (bus.wr_en) begin
          if (!en_seen) first_en = cyc;
          en_seen = 1;
          last_en = cyc;
        end
        if (bus.wr_en && run == 1 && bus.wr_data == cur) begin
          run = 2;
        end else begin
          if (run != 0) begin
            check("hold_cycles", run, 2);
            wq.push_back(cur);
          end
          if (bus.wr_en) begin
            run = 1;
            cur = bus.wr_data;
          end else begin
            run = 0;
          end
        end
        if (bus.pass_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wq.delete();
    en_seen = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (bus.pass_done) break;
      tick;
    end
    check(tag, bus.pass_done, 1);
    tick;
  endtask

  task automatic start_pass;
    bus.pass_start = 1'b1;
    tick;
    bus.pass_start = 1'b0;
  endtask

  int          start_cyc, acc, first_stall;
  int unsigned exp_q[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.pass_start = 1'b1;
    bus.pass_end   = 1'b0;
    bus.del_valid  = 1'b1;
    bus.del_addr   = 6'd5;
    tick; tick;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_pass_done", bus.pass_done, 0);
    check("rst_changed", bus.changed, 0);
    check("rst_del_count", bus.del_count, 0);
    check("rst_del_ready", bus.del_ready, 0);
    check("rst_busy", bus.busy, 0);
    bus.pass_start = 1'b0;
    bus.del_valid  = 1'b0;
    rst_n          = 1'b1;
    tick; tick;
    check("idle_del_ready", bus.del_ready, 0);
    check("idle_busy", bus.busy, 0);

    // Basic pass: 5, 9, 12 with pass_end on the last push.
    clear_mon;
    start_pass;
    start_cyc = cyc;
    check("collect_busy", bus.busy, 1);
    check("collect_ready", bus.del_ready, 1);
    bus.del_valid = 1'b1;
    bus.del_addr = 6'd5;  tick;
    bus.del_addr = 6'd9;  tick;
    bus.del_addr = 6'd12; bus.pass_end = 1'b1; tick;
    bus.del_valid = 1'b0; bus.pass_end = 1'b0;
    wait_done("basic_done");
    check("basic_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      check("basic_wr0", wq[0], 8'h05);
      check("basic_wr1", wq[1], 8'h09);
      check("basic_wr2", wq[2], 8'h0C);
    end
    check("basic_latency", first_en - start_cyc, 2);
    check("basic_span", last_en - first_en + 1, 6);
    check("basic_done_lag", done_cyc - last_en, 2);
    check("basic_count", bus.del_count, 3);
    check("basic_changed", bus.changed, 1);
    check("basic_idle", bus.busy, 0);

    // Empty pass.
    clear_mon;
    start_pass;
    bus.pass_end = 1'b1;
    tick;
    bus.pass_end = 1'b0;
    check("empty_drain_nodone", bus.pass_done, 0);
    tick;
    check("empty_done", bus.pass_done, 1);
    tick;
    check("empty_count", bus.del_count, 0);
    check("empty_changed", bus.changed, 0);
    check("empty_no_wr", en_seen, 0);

    // Backpressure: 0..19 offered back to back; occupancy reaches 8 after 15 accepts.
    clear_mon;
    start_pass;
    acc = 0;
    first_stall = -1;
    bus.del_valid = 1'b1;
    for (int i = 0; i < 200 && acc < 20; i++) begin
      bus.del_addr = 6'(acc);
      if (!bus.del_ready && first_stall < 0) first_stall = acc;
      if (bus.del_ready) begin
        tick;
        acc++;
      end else begin
        tick;
      end
    end
    bus.del_valid = 1'b0;
    check("bp_accepted", acc, 20);
    check("bp_first_stall", first_stall, 15);
    bus.pass_end = 1'b1;
    tick;
    bus.pass_end = 1'b0;
    wait_done("bp_done");
    check("bp_nwr", wq.size(), 20);
    if (wq.size() == 20)
      for (int i = 0; i < 20; i++) check($sformatf("bp_wr%0d", i), wq[i], i);
    check("bp_count", bus.del_count, 20);

    // Reset during DRAIN after the second write.
    clear_mon;
    start_pass;
    bus.del_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.del_addr = 6'(10 + i);
      bus.pass_end = (i == 5);
      tick;
    end
    bus.del_valid = 1'b0;
    bus.pass_end  = 1'b0;
    for (int i = 0; i < 100 && wq.size() < 2; i++) tick;
    check("mid_writes_seen", wq.size(), 2);
    check("mid_wr_active", bus.wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr_cut", bus.wr_en, 0);
    check("mid_busy_cut", bus.busy, 0);
    acc = done_cnt;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    check("mid_no_done", done_cnt, acc);
    clear_mon;
    start_pass;
    check("mid_next_count", bus.del_count, 0);
    check("mid_next_ready", bus.del_ready, 1);
    tick; tick; tick; tick;
    check("mid_next_no_wr", en_seen, 0);
    bus.pass_end = 1'b1;
    tick;
    bus.pass_end = 1'b0;
    wait_done("mid_next_done");
    check("mid_next_nwr", wq.size(), 0);
    check("mid_next_changed", bus.changed, 0);

    // Repeated addresses 7, 7, 3, 7.
`ifdef SKEL_DELETE_QUEUE_DEDUP_EN
    exp_q = '{7, 3, 7};
`else
    exp_q = '{7, 7, 3, 7};
`endif
    clear_mon;
    start_pass;
    bus.del_valid = 1'b1;
    bus.del_addr = 6'd7; tick;
    bus.del_addr = 6'd7; tick;
    bus.del_addr = 6'd3; tick;
    bus.del_addr = 6'd7; bus.pass_end = 1'b1; tick;
    bus.del_valid = 1'b0; bus.pass_end = 1'b0;
    wait_done("dup_done");
    check("dup_nwr", wq.size(), exp_q.size());
    if (wq.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check($sformatf("dup_wr%0d", i), wq[i], exp_q[i]);
    check("dup_count", bus.del_count, exp_q.size());
    check("dup_changed", bus.changed, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/skel_delete_queue.md
Name: skel_delete_queue

Overview:
- Upstream neighbour of the RAM write-port mux. Collects the addresses of pixels to be cleared during one thinning sub-iteration and buffers them in a FIFO.
- Drives them into the mux's internal-write input (we_two/data_1) at the rate that mux can sample.
- Tracks pass completion, so the top-level sequencer knows when a sub-iteration is finished and whether the image changed.

Parameters:
- N, 8, image side length; image holds N*N pixels.
- bitSize, 6, pixel address width (log2(N*N)).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 7, deletion counter width; must hold N*N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pass_start  in  1  single-cycle pulse that opens a sub-iteration.
- pass_end  in  1  single-cycle pulse; the upstream scan has issued its last deletion.
- del_valid  in  1  deletion request valid.
- del_addr  in  bitSize  pixel address to clear.
- del_ready  out  1  request accepted this cycle when del_valid && del_ready.
- wr_en  out  1  to write mux we_two.
- wr_data  out  8  to write mux data_1; del_addr zero-extended to 8 bits.
- pass_done  out  1  one-cycle pulse when all of the pass's writes have completed.
- changed  out  1  at least one deletion issued in the last completed pass.
- del_count  out  CNT_W  writes issued in the current or last pass.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE and the FIFO is emptied.
  - All outputs are 0: wr_en, wr_data, pass_done, changed, del_count, del_ready, busy.
- States:
  - IDLE: del_ready=0. pass_start moves to COLLECT; on that edge del_count and changed clear to 0.
  - COLLECT:
    - del_ready = !full. A push happens on an edge where del_valid && del_ready.
    - pass_end moves to DRAIN. A push in the same cycle as pass_end is accepted.
  - DRAIN: del_ready=0. Keep issuing writes. Move to DONE when the FIFO is empty and no write is being held.
  - DONE: one cycle. pass_done=1; changed <= (del_count != 0). Return to IDLE.
- pass_start outside IDLE and pass_end outside COLLECT are ignored.
- Write issue:
  - Every write holds wr_en=1 and a stable wr_data for exactly 2 consecutive cycles. The mux samples on alternate edges, so every write is captured whatever the mux phase.
  - A pop happens on an edge where the FIFO is non-empty and no hold is active, or the hold ends on that edge. This allows back-to-back writes at 1 write per 2 cycles.
  - wr_en returns to 0 when nothing is pending.
  - Each pop increments del_count, saturating at 2^CNT_W-1.
- Latency:
  - A push into an empty, idle-output FIFO at edge t gives wr_en=1 from edge t+1.
  - pass_done asserts 1 cycle after the last write's hold ends.
- FIFO full/empty:
  - full is computed from the current occupancy. No same-cycle bypass, so del_ready=0 when full even if a pop occurs on that edge.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full and not empty leaves occupancy unchanged.
- changed and del_count hold their values from pass_done until the next pass_start.
- Reset during COLLECT or DRAIN abandons the pass: no pass_done, pending addresses are discarded, and any wr_en hold is cut immediately.

Optional Feature:
- Macro: SKEL_DELETE_QUEUE_DEDUP_EN.
- Defined:
  - A push whose del_addr equals the most recently accepted address of the current pass is handshaken (del_ready as normal) but not stored, not written and not counted.
  - The last-address register is invalidated at pass_start and reset.
- Undefined: every accepted request is stored and written. No comparator or last-address register is built.

Test Plan:
- Reset: hold rst_n=0 with del_valid=1 and pass_start=1 -> all outputs 0, busy=0. Release -> IDLE; del_ready stays 0 until pass_start.
- Basic pass: pass_start; push addresses 5, 9, 12 on consecutive cycles; pass_end -> wr_data sequence 0x05, 0x09, 0x0C, each with wr_en held 2 cycles and no gaps; then pass_done pulse, del_count=3, changed=1.
- Empty pass: pass_start, then pass_end the next cycle with no pushes -> pass_done 1 cycle after entering DRAIN, del_count=0, changed=0, wr_en never asserted.
- Backpressure: hold del_valid=1 with incrementing addresses 0..19 for 20 cycles with DEPTH=8 -> del_ready drops once occupancy hits 8, with no lost or duplicated address. After pass_end, wr_data order is 0..19 and del_count=20.
- Reset mid-DRAIN: push 6 addresses, pass_end, assert rst_n=0 after the 2nd write -> wr_en falls asynchronously and no pass_done occurs. The next pass starts with an empty FIFO and del_count=0.
- With SKEL_DELETE_QUEUE_DEDUP_EN: push 7, 7, 3, 7 -> writes 0x07, 0x03, 0x07 and del_count=3. Without the macro, 4 writes are issued and del_count=4.
